tb_ram_port_arbiter: RTL and testbench
======================================

// Module: tb_ram_port_arbiter
// PURPOSE
//  Shares the bench's single-port synchronous RAM between three OBI-style requesters:
//  - the firmware loader port
//  - the core instruction port
//  - the core data port
//  Sits inside tb_subsystem between the core's OBI ports and the RAM macro.
//  - Grants one request per cycle and routes the 1-cycle-latency response back to its owner.
//  - Counts per-port stall cycles for bench performance reporting.
// PARAMETERS
//  RAM_ADDR_WIDTH  16  word-address bits of the RAM (depth = 2**RAM_ADDR_WIDTH words)
//  CNT_WIDTH       32  width of each stall counter
// PORTS
//  clk              in   1   clock
//  rst_n            in   1   asynchronous active-low reset
//  ld_hold_i        in   1   1 = loader session active; core ports get no grants
//  ld_req_i/ld_we_i in   1   loader request / write enable (loader writes full words, be=4'hF)
//  ld_addr_i        in   32  loader byte address
//  ld_wdata_i       in   32  loader write data
//  ld_gnt_o         out  1   loader grant
//  ld_rvalid_o      out  1   loader response valid
//  instr_req_i      in   1   fetch request (read only)
//  instr_addr_i     in   32  fetch byte address
//  instr_gnt_o      out  1   fetch grant
//  instr_rvalid_o   out  1   fetch response valid
//  instr_rdata_o    out  32  fetch read data
//  data_req_i/data_we_i in 1 data request / write enable
//  data_be_i        in   4   data byte enables
//  data_addr_i      in   32  data byte address
//  data_wdata_i     in   32  data write data
//  data_gnt_o       out  1   data grant
//  data_rvalid_o    out  1   data response valid
//  data_rdata_o     out  32  data read data
//  mem_req_o/mem_we_o out 1  RAM enable / write enable
//  mem_be_o         out  4   RAM byte enables
//  mem_addr_o       out  RAM_ADDR_WIDTH  RAM word address
//  mem_wdata_o      out  32  RAM write data
//  mem_rdata_i      in   32  RAM read data, valid 1 cycle after mem_req_o
//  cnt_clr_i        in   1   synchronous clear of both stall counters
//  instr_stall_o    out  CNT_WIDTH  cycles with instr_req_i=1 and instr_gnt_o=0
//  data_stall_o     out  CNT_WIDTH  cycles with data_req_i=1 and data_gnt_o=0
// BEHAVIOUR
//  Reset values:
//  - all rvalid outputs 0; stall counters 0; pending-owner register = NONE.
//  - round-robin pointer rr_last = INSTR, so data wins the first core tie.
//  Grants (combinational, same cycle as req; at most one grant per cycle):
//  - Loader has strict priority: ld_req_i=1 -> ld_gnt_o=1.
//  - ld_hold_i=1 -> instr_gnt_o = data_gnt_o = 0, whether or not ld_req_i is high.
//  - Else, only one core port requesting -> that port is granted.
//  - Else, both requesting -> grant the port not equal to rr_last.
//  - rr_last <= granted core port on every core grant (loader grants leave it unchanged).
//  RAM drive:
//  - mem_req_o = OR of grants. Address/data/we/be are muxed from the granted port.
//  - mem_addr_o = addr[RAM_ADDR_WIDTH+1:2]. Upper address bits are ignored, so addresses wrap modulo RAM size.
//  - instr port: mem_we_o=0. Loader port: mem_be_o=4'hF.
//  Response:
//  - The pending-owner register captures the granted port at the clock edge.
//  - Next cycle, exactly that port's rvalid=1 (reads and writes alike), then owner returns to NONE.
//  - Latency is fixed at 1 cycle; back-to-back grants yield back-to-back rvalids.
//  - instr_rdata_o = data_rdata_o = mem_rdata_i, unregistered. Content is meaningful only when the port's rvalid=1.
//  Stall counters:
//  - +1 per qualifying cycle; saturate at all-ones (no wrap).
//  - cnt_clr_i has priority over increment.
//  Reset mid-operation:
//  - A pending response is discarded; no rvalid is emitted after rst_n rises.
//  - Counters return to 0.
//  Req after gnt:
//  - Requesters may drop req only after gnt (OBI rule).
//  - The arbiter does not check this; an ungranted req may change.
// TESTING
//  - Reset: assert rst_n=0 with req pending -> all gnt/rvalid 0; counters 0; first tie (instr+data req) grants data.
//  - Loader: ld_hold_i=1, write 0xDEADBEEF @0x100 then read @0x100 -> ld_rvalid_o 1 cycle after each gnt; cores ungranted; instr_stall_o counts hold cycles.
//  - Round-robin: instr and data both request continuously for 6 cycles -> grants alternate D,I,D,I,D,I; each stall counter = 3.
//  - Priority: ld_req_i, instr_req_i and data_req_i all high in one cycle -> only ld_gnt_o; mem_be_o=4'hF.
//  - Byte write: data be=4'b0010 wdata 0x0000AB00 @0x204 -> mem_addr_o=0x81, mem_be_o=0x2; data_rvalid_o next cycle.
//  - Saturation/clear: force stall counter to all-ones then one more stall cycle -> holds all-ones; cnt_clr_i=1 -> 0 next cycle.

Source files
------------

// File: rtl/tb_ram_port_arbiter.sv
// ============================================================================
// Module      : tb_ram_port_arbiter
// Description : Shares one single-port synchronous RAM between the loader,
//               core instruction and core data OBI ports; counts stalls.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ram_port_arbiter #(
    parameter int RAM_ADDR_WIDTH = 16,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ld_hold_i,
    input  logic                      ld_req_i,
    input  logic                      ld_we_i,
    input  logic [31:0]               ld_addr_i,
    input  logic [31:0]               ld_wdata_i,
    output logic                      ld_gnt_o,
    output logic                      ld_rvalid_o,
    input  logic                      instr_req_i,
    input  logic [31:0]               instr_addr_i,
    output logic                      instr_gnt_o,
    output logic                      instr_rvalid_o,
    output logic [31:0]               instr_rdata_o,
    input  logic                      data_req_i,
    input  logic                      data_we_i,
    input  logic [3:0]                data_be_i,
    input  logic [31:0]               data_addr_i,
    input  logic [31:0]               data_wdata_i,
    output logic                      data_gnt_o,
    output logic                      data_rvalid_o,
    output logic [31:0]               data_rdata_o,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic [RAM_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    input  logic [31:0]               mem_rdata_i,
    input  logic                      cnt_clr_i,
    output logic [CNT_WIDTH-1:0]      instr_stall_o,
    output logic [CNT_WIDTH-1:0]      data_stall_o
);

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_LD    = 2'd1;
    localparam logic [1:0] OWN_INSTR = 2'd2;
    localparam logic [1:0] OWN_DATA  = 2'd3;

    localparam logic RR_INSTR = 1'b0;
    localparam logic RR_DATA  = 1'b1;

    localparam logic [CNT_WIDTH-1:0] CNT_ONES = '1;

    logic [1:0]           owner_q, owner_d;
    logic                 rr_last_q, rr_last_d;
    logic [CNT_WIDTH-1:0] instr_stall_q, instr_stall_d;
    logic [CNT_WIDTH-1:0] data_stall_q, data_stall_d;
    logic                 core_ok;

    // Word-address bits outside the RAM window are intentionally dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ld_addr_i[31:RAM_ADDR_WIDTH+2], ld_addr_i[1:0],
                                instr_addr_i[31:RAM_ADDR_WIDTH+2], instr_addr_i[1:0],
                                data_addr_i[31:RAM_ADDR_WIDTH+2], data_addr_i[1:0]};

    // No RAM access is issued while reset is asserted.
    always_comb begin
        core_ok     = rst_n & ~ld_hold_i & ~ld_req_i;
        ld_gnt_o    = rst_n & ld_req_i;
        instr_gnt_o = core_ok & instr_req_i & (~data_req_i | (rr_last_q == RR_DATA));
        data_gnt_o  = core_ok & data_req_i & (~instr_req_i | (rr_last_q == RR_INSTR));
    end

    always_comb begin
        mem_req_o   = ld_gnt_o | instr_gnt_o | data_gnt_o;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ld_gnt_o) begin
            mem_we_o    = ld_we_i;
            mem_be_o    = 4'hF;
            mem_addr_o  = ld_addr_i[RAM_ADDR_WIDTH+1:2];
            mem_wdata_o = ld_wdata_i;
        end else if (instr_gnt_o) begin
            mem_be_o    = 4'hF;
            mem_addr_o  = instr_addr_i[RAM_ADDR_WIDTH+1:2];
        end else if (data_gnt_o) begin
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i[RAM_ADDR_WIDTH+1:2];
            mem_wdata_o = data_wdata_i;
        end
    end

    always_comb begin
        owner_d       = OWN_NONE;
        rr_last_d     = rr_last_q;
        instr_stall_d = instr_stall_q;
        data_stall_d  = data_stall_q;
        if (ld_gnt_o) begin
            owner_d = OWN_LD;
        end else if (instr_gnt_o) begin
            owner_d   = OWN_INSTR;
            rr_last_d = RR_INSTR;
        end else if (data_gnt_o) begin
            owner_d   = OWN_DATA;
            rr_last_d = RR_DATA;
        end
        if (cnt_clr_i) begin
            instr_stall_d = '0;
            data_stall_d  = '0;
        end else begin
            if (instr_req_i && !instr_gnt_o && instr_stall_q != CNT_ONES) begin
                instr_stall_d = instr_stall_q + 1'b1;
            end
            if (data_req_i && !data_gnt_o && data_stall_q != CNT_ONES) begin
                data_stall_d = data_stall_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q       <= OWN_NONE;
            rr_last_q     <= RR_INSTR;
            instr_stall_q <= '0;
            data_stall_q  <= '0;
        end else begin
            owner_q       <= owner_d;
            rr_last_q     <= rr_last_d;
            instr_stall_q <= instr_stall_d;
            data_stall_q  <= data_stall_d;
        end
    end

    assign ld_rvalid_o    = (owner_q == OWN_LD);
    assign instr_rvalid_o = (owner_q == OWN_INSTR);
    assign data_rvalid_o  = (owner_q == OWN_DATA);
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_stall_o  = instr_stall_q;
    assign data_stall_o   = data_stall_q;

endmodule

`default_nettype wire

// File: tb/tb_tb_ram_port_arbiter.sv
// Bench for tb_ram_port_arbiter: behavioural RAM, response scoreboard and
// one task per scenario.
`default_nettype none

module tb_tb_ram_port_arbiter;

    localparam int AW = 16;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_hold_i = 0, ld_req_i = 0, ld_we_i = 0;
    logic [31:0]   ld_addr_i = 0, ld_wdata_i = 0;
    logic          ld_gnt_o, ld_rvalid_o;
    logic          instr_req_i = 0;
    logic [31:0]   instr_addr_i = 0;
    logic          instr_gnt_o, instr_rvalid_o;
    logic [31:0]   instr_rdata_o;
    logic          data_req_i = 0, data_we_i = 0;
    logic [3:0]    data_be_i = 0;
    logic [31:0]   data_addr_i = 0, data_wdata_i = 0;
    logic          data_gnt_o, data_rvalid_o;
    logic [31:0]   data_rdata_o;
    logic          mem_req_o, mem_we_o;
    logic [3:0]    mem_be_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i = 0;
    logic          cnt_clr_i = 0;
    logic [CW-1:0] instr_stall_o, data_stall_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  vld;   // {ld, instr, data}
        logic        chk;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic        mon_en = 1'b0;
    logic [31:0] model_mem [logic [15:0]];
    logic [31:0] ram [logic [15:0]];
    logic [31:0] ram_cur;

    tb_ram_port_arbiter #(.RAM_ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_hold_i(ld_hold_i), .ld_req_i(ld_req_i), .ld_we_i(ld_we_i),
        .ld_addr_i(ld_addr_i), .ld_wdata_i(ld_wdata_i),
        .ld_gnt_o(ld_gnt_o), .ld_rvalid_o(ld_rvalid_o),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
        .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
        .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i),
        .cnt_clr_i(cnt_clr_i),
        .instr_stall_o(instr_stall_o), .data_stall_o(data_stall_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_req_o) begin
            ram_cur = ram.exists(mem_addr_o) ? ram[mem_addr_o] : 32'h0;
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) ram_cur[b*8 +: 8] = mem_wdata_o[b*8 +: 8];
                ram[mem_addr_o] = ram_cur;
            end else begin
                mem_rdata_i <= ram_cur;
            end
        end
    end

    // Every cycle, the response port must match exactly what was granted one cycle earlier.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            exp_t e;
            e.vld = 3'b000; e.chk = 1'b0; e.data = 32'h0;
            if (sb.size() > 0) e = sb.pop_front();
            checks++;
            if ({ld_rvalid_o, instr_rvalid_o, data_rvalid_o} !== e.vld) begin
                errors++;
                $display("FAIL rvalid: got %b want %b", {ld_rvalid_o, instr_rvalid_o, data_rvalid_o}, e.vld);
            end
            if (e.chk) begin
                checks++;
                if ((e.vld[1] ? instr_rdata_o : data_rdata_o) !== e.data) begin
                    errors++;
                    $display("FAIL rdata: got %h want %h", e.vld[1] ? instr_rdata_o : data_rdata_o, e.data);
                end
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        logic [15:0] w;
        w = a[17:2];
        return model_mem.exists(w) ? model_mem[w] : 32'h0;
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        logic [31:0] cur;
        cur = model_rd(a);
        for (int b = 0; b < 4; b++) if (be[b]) cur[b*8 +: 8] = d[b*8 +: 8];
        model_mem[a[17:2]] = cur;
    endtask

    task automatic push(input logic [2:0] vld, input logic chk, input logic [31:0] d);
        exp_t e;
        e.vld = vld; e.chk = chk; e.data = d;
        sb.push_back(e);
    endtask

    task automatic idle();
        ld_hold_i = 0; ld_req_i = 0; ld_we_i = 0; instr_req_i = 0;
        data_req_i = 0; data_we_i = 0; cnt_clr_i = 0;
    endtask

    task automatic clear_counters();
        @(negedge clk); cnt_clr_i = 1;
        @(negedge clk); cnt_clr_i = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        ld_req_i = 1; ld_addr_i = 32'h0; instr_req_i = 1; instr_addr_i = 32'h0;
        @(posedge clk); #2;
        rst_n = 0; ld_req_i = 0; data_req_i = 1; data_addr_i = 32'h0;
        #1;
        checks++;
        if ({ld_rvalid_o, instr_rvalid_o, data_rvalid_o, ld_gnt_o, instr_gnt_o, data_gnt_o, mem_req_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {ld_rvalid_o, instr_rvalid_o, data_rvalid_o, ld_gnt_o, instr_gnt_o, data_gnt_o, mem_req_o});
        end
        checks++;
        if (instr_stall_o !== 4'd0 || data_stall_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", instr_stall_o, data_stall_o);
        end
        @(negedge clk); @(negedge clk);
        rst_n = 1; #1;
        mon_en = 1;
        checks++;
        if ({ld_gnt_o, instr_gnt_o, data_gnt_o} !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_tie: got %b want 001", {ld_gnt_o, instr_gnt_o, data_gnt_o});
        end
        push(3'b001, 1'b1, model_rd(32'h0));
        @(negedge clk); idle();
    endtask

    task automatic test_loader();
        clear_counters();
        @(negedge clk);
        ld_hold_i = 1; instr_req_i = 1; instr_addr_i = 32'h8;
        ld_req_i = 1; ld_we_i = 1; ld_addr_i = 32'h100; ld_wdata_i = 32'hDEADBEEF;
        #1;
        checks++;
        if ({ld_gnt_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o} !== 8'b1001_1111 || mem_addr_o !== 16'h0040) begin
            errors++;
            $display("FAIL ld_write: got gnt/we/be %b addr %h want 10011111 addr 0040",
                     {ld_gnt_o, instr_gnt_o, data_gnt_o, mem_we_o, mem_be_o}, mem_addr_o);
        end
        push(3'b100, 1'b0, 32'h0);
        model_wr(32'h100, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        ld_we_i = 0; #1;
        checks++;
        if ({ld_gnt_o, instr_gnt_o, mem_we_o} !== 3'b100) begin
            errors++;
            $display("FAIL ld_read: got %b want 100", {ld_gnt_o, instr_gnt_o, mem_we_o});
        end
        push(3'b100, 1'b0, 32'h0);
        @(negedge clk);
        ld_req_i = 0; #1;
        checks++;
        if ({instr_gnt_o, mem_req_o} !== 2'b00) begin
            errors++;
            $display("FAIL ld_hold_block: got %b want 00", {instr_gnt_o, mem_req_o});
        end
        @(negedge clk);
        idle(); #1;
        checks++;
        if (instr_stall_o !== 4'd3) begin
            errors++;
            $display("FAIL ld_hold_stall: got %0d want 3", instr_stall_o);
        end
        // Read back the loaded word through the data port.
        data_req_i = 1; data_addr_i = 32'h100; #1;
        push(3'b001, 1'b1, model_rd(32'h100));
        @(negedge clk); idle();
    endtask

    task automatic test_round_robin();
        logic [2:0] want;
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            instr_req_i = 1; instr_addr_i = 32'h100;
            data_req_i = 1; data_we_i = 0; data_addr_i = 32'h0;
            #1;
            want = (i % 2 == 0) ? 3'b001 : 3'b010;
            checks++;
            if ({ld_gnt_o, instr_gnt_o, data_gnt_o} !== want) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got %b want %b", i, {ld_gnt_o, instr_gnt_o, data_gnt_o}, want);
            end
            push(want, 1'b1, want[1] ? model_rd(32'h100) : model_rd(32'h0));
        end
        @(negedge clk); idle(); #1;
        checks++;
        if (instr_stall_o !== 4'd3 || data_stall_o !== 4'd3) begin
            errors++;
            $display("FAIL rr_stalls: got %0d/%0d want 3/3", instr_stall_o, data_stall_o);
        end
    endtask

    task automatic test_priority();
        @(negedge clk);
        ld_req_i = 1; ld_we_i = 0; ld_addr_i = 32'h100;
        instr_req_i = 1; data_req_i = 1; data_be_i = 4'b0011;
        #1;
        checks++;
        if ({ld_gnt_o, instr_gnt_o, data_gnt_o} !== 3'b100 || mem_be_o !== 4'hF) begin
            errors++;
            $display("FAIL priority: got gnt %b be %h want 100 be F", {ld_gnt_o, instr_gnt_o, data_gnt_o}, mem_be_o);
        end
        push(3'b100, 1'b0, 32'h0);
        @(negedge clk); idle();
    endtask

    task automatic test_byte_write();
        @(negedge clk);
        data_req_i = 1; data_we_i = 1; data_be_i = 4'b0010;
        data_addr_i = 32'h204; data_wdata_i = 32'h0000AB00;
        #1;
        checks++;
        if (mem_addr_o !== 16'h0081 || mem_be_o !== 4'h2 || mem_we_o !== 1'b1 || mem_wdata_o !== 32'h0000AB00) begin
            errors++;
            $display("FAIL byte_write: got addr %h be %h we %b wd %h want 0081 2 1 0000ab00",
                     mem_addr_o, mem_be_o, mem_we_o, mem_wdata_o);
        end
        push(3'b001, 1'b0, 32'h0);
        model_wr(32'h204, 4'b0010, 32'h0000AB00);
        @(negedge clk);
        // An aliased address above the RAM window lands on the same word.
        idle(); instr_req_i = 1; instr_addr_i = 32'h0004_0204; #1;
        checks++;
        if (mem_addr_o !== 16'h0081 || instr_gnt_o !== 1'b1 || mem_we_o !== 1'b0) begin
            errors++;
            $display("FAIL addr_wrap: got addr %h gnt %b we %b want 0081 1 0", mem_addr_o, instr_gnt_o, mem_we_o);
        end
        push(3'b010, 1'b1, model_rd(32'h204));
        @(negedge clk); idle();
    endtask

    task automatic test_saturation();
        clear_counters();
        @(negedge clk);
        ld_hold_i = 1; data_req_i = 1;
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (data_stall_o !== 4'hF) begin
            errors++;
            $display("FAIL sat_reach: got %0d want 15", data_stall_o);
        end
        @(negedge clk); #1;
        checks++;
        if (data_stall_o !== 4'hF) begin
            errors++;
            $display("FAIL sat_hold: got %0d want 15", data_stall_o);
        end
        cnt_clr_i = 1;
        @(negedge clk); #1;
        checks++;
        if (data_stall_o !== 4'd0 || instr_stall_o !== 4'd0) begin
            errors++;
            $display("FAIL sat_clear: got %0d/%0d want 0/0", data_stall_o, instr_stall_o);
        end
        idle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst_n = 1;
        test_reset();
        test_loader();
        test_round_robin();
        test_priority();
        test_byte_write();
        test_saturation();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
